nand_chain_seq: RTL and testbench

Sequencer that evaluates the three-stage NAND chain E=~(A&B), F=~(E&C), G=~(F&D) using one shared 2-input NAND unit, time-multiplexed over three cycles.
- Operands are accepted with a valid/ready handshake and the result is returned with a valid/ready handshake.
- Intermediate E and F are held in registers between steps.
- The block sits between the lab-board input/switch logic and the result display, replacing the fully combinational chain with a resource-shared, clocked version.

---
 rtl/nand_chain_pkg.sv | 21 ++
 rtl/nand_chain_seq_nand2_unit.sv | 19 +
 rtl/nand_chain_seq.sv | 161 ++++++++++++++++
 tb/tb_nand_chain_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nand_chain_pkg.sv
// Shared definitions for the NAND-chain sequencer: FSM state encoding and
// default parameter values.
package nand_chain_pkg;

  // Width of the sequencer state register
  localparam int STATE_W = 3;

  // Default operand width and completed-operation counter width
  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 8;

  // Sequencer states: capture, three NAND steps, then result presentation
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    S_E   = 3'd1,
    S_F   = 3'd2,
    S_G   = 3'd3,
    S_OUT = 3'd4
  } state_t;

endpackage

// File: rtl/nand_chain_seq_nand2_unit.sv
// Bitwise 2-input NAND, purely combinational. The sequencer owns exactly one
// instance and time-multiplexes it across the three chain stages.
module nand2_unit #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] y
);

  // One NAND gate per bit lane; lanes never interact
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_lane
      assign y[gi] = ~(x0[gi] & x1[gi]);
    end
  endgenerate

endmodule

// File: rtl/nand_chain_seq.sv
// Resource-shared evaluation of G = ~(~(~(A&B)&C)&D).
// One nand2_unit is reused over three cycles (S_E, S_F, S_G); operands come
// in and the result goes out over valid/ready handshakes.
// Optional build macro NAND_CHAIN_STEP_EN adds a 'step' input that gates
// progress through S_E/S_F/S_G for single-stepping on the lab board.
module nand_chain_seq
  import nand_chain_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
`ifdef NAND_CHAIN_STEP_EN
  input  logic             step,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg, b_reg, c_reg, d_reg;
  logic [WIDTH-1:0] e_reg, f_reg, g_reg;
  logic [CNT_W-1:0] op_count_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  logic [WIDTH-1:0] nand_x0_next, nand_x1_next;
  logic [WIDTH-1:0] nand_y;
  logic             advance;

  // Stage-advance qualifier for S_E/S_F/S_G
`ifdef NAND_CHAIN_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  // Route the operands of the active stage into the shared NAND; zero when idle
  always_comb begin
    nand_x0_next = '0;
    nand_x1_next = '0;
    case (state_reg)
      S_E: begin
        nand_x0_next = a_reg;
        nand_x1_next = b_reg;
      end
      S_F: begin
        nand_x0_next = e_reg;
        nand_x1_next = c_reg;
      end
      S_G: begin
        nand_x0_next = f_reg;
        nand_x1_next = d_reg;
      end
      default: begin
        nand_x0_next = '0;
        nand_x1_next = '0;
      end
    endcase
  end

  nand2_unit #(
    .WIDTH(WIDTH)
  ) u_nand (
    .x0(nand_x0_next),
    .x1(nand_x1_next),
    .y (nand_y)
  );

  // Sequencer FSM with registered handshake/status outputs and data path
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      d_reg         <= '0;
      e_reg         <= '0;
      f_reg         <= '0;
      g_reg         <= '0;
      op_count_reg  <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Operands are sampled only on the accepting edge
          if (in_valid && in_ready_reg) begin
            a_reg        <= a;
            b_reg        <= b;
            c_reg        <= c;
            d_reg        <= d;
            state_reg    <= S_E;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        S_E: begin
          if (advance) begin
            e_reg     <= nand_y;
            state_reg <= S_F;
          end
        end
        S_F: begin
          if (advance) begin
            f_reg     <= nand_y;
            state_reg <= S_G;
          end
        end
        S_G: begin
          if (advance) begin
            g_reg         <= nand_y;
            state_reg     <= S_OUT;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        S_OUT: begin
          // Result registers are untouched here, so they hold during a stall
          if (out_ready) begin
            op_count_reg  <= op_count_reg + CNT_ONE;
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign e         = e_reg;
  assign f         = f_reg;
  assign g         = g_reg;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_nand_chain_seq.sv
// Scoreboard bench for nand_chain_seq (WIDTH=4, CNT_W=2). The driver pushes
// hand-computed expectations on each accept; a monitor pops them on every
// output handshake.
module tb_nand_chain_seq;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0, b = '0, c = '0, d = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  g, e, f;
  logic          busy;
  logic [CW-1:0] op_count;

  nand_chain_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef NAND_CHAIN_STEP_EN
    .step     (1'b1),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .g        (g),
    .e        (e),
    .f        (f),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  e;
    logic [W-1:0]  f;
    logic [W-1:0]  g;
    logic [CW-1:0] cnt;
    int            acc_cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [CW-1:0] cnt_model = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one operand set; on accept optionally push the expected result
  task automatic issue(input logic [W-1:0] ia, ib, ic, id,
                       input logic [W-1:0] xe, xf, xg, input bit push);
    int   n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {31'd0, in_ready}, 32'd1);
    a = ia; b = ib; c = ic; d = id;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("issue a=%b b=%b c=%b d=%b at cycle %0d", ia, ib, ic, id, cyc);
    if (push) begin
      cnt_model = cnt_model + 1'b1;
      x.e = xe; x.f = xf; x.g = xg; x.cnt = cnt_model; x.acc_cyc = cyc;
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  // Monitor: latency on out_valid rise, data on handshake, count one cycle later
  initial begin
    logic          prev_valid;
    logic          cnt_chk;
    logic [CW-1:0] cnt_exp;
    exp_t          x;
    prev_valid = 1'b0;
    cnt_chk    = 1'b0;
    cnt_exp    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        cnt_chk    = 1'b0;
      end else begin
        if (cnt_chk) begin
          chk("op_count", op_count, cnt_exp);
          cnt_chk = 1'b0;
        end
        if (out_valid && !prev_valid) begin
          if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
          else chk("latency", cyc - sb[0].acc_cyc, 32'd3);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            x = sb.pop_front();
            $display("result e=%b f=%b g=%b (exp %b %b %b) cycle %0d",
                     e, f, g, x.e, x.f, x.g, cyc);
            chk("e", e, x.e);
            chk("f", f, x.f);
            chk("g", g, x.g);
            cnt_exp = x.cnt;
            cnt_chk = 1'b1;
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $finish;
  end

  initial begin
    logic [W-1:0] g_hold;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_efg", {e, f, g}, 0);

    // Back-to-back with out_ready=1
    issue(4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1);
    issue(4'b1111, 4'b1111, 4'b1010, 4'b0110, 4'b0000, 4'b1111, 4'b1001, 1);
    drain();

    // Consumer stall for 10 cycles
    @(posedge clk); #1 out_ready = 1'b0;
    issue(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    g_hold = g;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_g", g, 4'b1111);
      chk("stall_g_stable", g, g_hold);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Operand changes and in_valid pulses while busy are ignored
    issue(4'b1100, 4'b1010, 4'b0101, 4'b1111, 4'b0111, 4'b1010, 4'b0101, 1);
    a = 4'b1111; b = 4'b1111; c = 4'b1111; d = 4'b1111;
    in_valid = 1'b1;
    @(negedge clk);
    chk("busy_high", busy, 1);
    chk("busy_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

    issue(4'b0011, 4'b0110, 4'b1011, 4'b0100, 4'b1101, 4'b0110, 4'b1011, 1);
    drain();

    // Reset pulsed while in S_F discards the operation
    issue(4'b1010, 4'b0101, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    cnt_model = '0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_efg", {e, f, g}, 0);
    chk("midrst_op_count", op_count, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", out_valid, 0);
    end

    issue(4'b1111, 4'b0000, 4'b0000, 4'b1010, 4'b1111, 4'b1111, 4'b0101, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
